seg_sum_unit: RTL and testbench

Parametrised segment-sum and event-counter unit. It splits a wide input word into NSEG equal segments and returns their full-precision sum through a 2-stage valid/ready pipeline. A modulo-CNT_MOD up/down counter runs alongside, with clear, saturation mode and a wrap pulse. It is the next generation of the fixed 100-bit two-half adder with 3-bit counter: arbitrary width and segment count, backpressure, and all logic on the rising clock edge.

---
 rtl/seg_sum_pkg.sv | 10 +
 rtl/seg_sum_counter.sv | 37 +++
 rtl/seg_sum_unit.sv | 64 ++++++
 tb/tb_seg_sum_unit.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/seg_sum_pkg.sv
// seg_sum_pkg: shared widths, configuration checks and counter direction encoding
package seg_sum_pkg;
    typedef enum logic {CNT_DOWN = 1'b0, CNT_UP = 1'b1} cnt_dir_e;
    function automatic int sum_w(input int data_w, input int nseg);
        return data_w / nseg + $clog2(nseg);
    endfunction
    function automatic bit cfg_ok(input int data_w, input int nseg, input int cnt_w, input int cnt_mod);
        return nseg >= 2 && data_w % nseg == 0 && cnt_mod >= 2 && cnt_mod <= 2 ** cnt_w;
    endfunction
endpackage

// File: rtl/seg_sum_counter.sv
// seg_sum_counter: modulo-CNT_MOD up/down counter with wrap or saturate and a registered wrap pulse
module seg_sum_counter
    import seg_sum_pkg::*;
#(
    parameter int CNT_W   = 4,
    parameter int CNT_MOD = 8,
    parameter int CNT_SAT = 0
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             cnt_en,
    input  logic             cnt_dir,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] cnt_q,
    output logic             cnt_wrap
);
    localparam logic [CNT_W-1:0] TOP = CNT_W'(CNT_MOD - 1);
    logic             up, at_bnd, wrap_ev;
    logic [CNT_W-1:0] bnd_next, cnt_d;
    always_comb begin
        up       = cnt_dir_e'(cnt_dir) == CNT_UP;
        at_bnd   = up ? cnt_q == TOP : cnt_q == '0;
        bnd_next = CNT_SAT != 0 ? cnt_q : (up ? '0 : TOP);
        wrap_ev  = !cnt_clr && cnt_en && at_bnd;
        cnt_d    = cnt_clr ? '0 : !cnt_en ? cnt_q : at_bnd ? bnd_next :
                   up ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
    end
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            cnt_q    <= '0;
            cnt_wrap <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            cnt_wrap <= wrap_ev;
        end
    end
endmodule

// File: rtl/seg_sum_unit.sv
// seg_sum_unit: 2-stage valid/ready segment-sum pipeline with an independent event counter
module seg_sum_unit
    import seg_sum_pkg::*;
#(
    parameter int DATA_W  = 100,
    parameter int NSEG    = 2,
    parameter int CNT_W   = 4,
    parameter int CNT_MOD = 8,
    parameter int CNT_SAT = 0
) (
    input  logic                             clk,
    input  logic                             async_reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_W-1:0]                in_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [sum_w(DATA_W, NSEG)-1:0]   out_sum,
    input  logic                             cnt_en,
    input  logic                             cnt_dir,
    input  logic                             cnt_clr,
    output logic [CNT_W-1:0]                 cnt_q,
    output logic                             cnt_wrap
);
    localparam int SEG_W = DATA_W / NSEG;
    localparam int SUM_W = sum_w(DATA_W, NSEG);
    if (!cfg_ok(DATA_W, NSEG, CNT_W, CNT_MOD)) begin : g_bad_cfg
        $error("seg_sum_unit: illegal DATA_W/NSEG/CNT_W/CNT_MOD combination");
    end
    logic              s1_valid, s1_adv, s2_adv;
    logic [DATA_W-1:0] s1_data;
    logic [SUM_W-1:0]  seg_total;
    always_comb begin
        s2_adv    = !out_valid || out_ready;
        s1_adv    = !s1_valid || s2_adv;
        in_ready  = s1_adv && !async_reset;
        seg_total = '0;
        for (int k = 0; k < NSEG; k++)
            seg_total = seg_total + SUM_W'(s1_data[k*SEG_W +: SEG_W]);
    end
    // Registers only load when a real word moves in, so held data stays quiet in bubbles.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
        end else begin
            if (s1_adv) s1_valid <= in_valid;
            if (s1_adv && in_valid) s1_data <= in_data;
            if (s2_adv) out_valid <= s1_valid;
            if (s2_adv && s1_valid) out_sum <= seg_total;
        end
    end
    seg_sum_counter #(.CNT_W(CNT_W), .CNT_MOD(CNT_MOD), .CNT_SAT(CNT_SAT)) u_counter (
        .clk         (clk),
        .async_reset (async_reset),
        .cnt_en      (cnt_en),
        .cnt_dir     (cnt_dir),
        .cnt_clr     (cnt_clr),
        .cnt_q       (cnt_q),
        .cnt_wrap    (cnt_wrap)
    );
endmodule

// File: tb/tb_seg_sum_unit.sv
// tb_seg_sum_unit: directed checks of the default 100/2 wrapping unit and a 32/4 saturating unit
module tb_seg_sum_unit;
    logic clk = 1'b0;
    logic async_reset = 1'b1;
    always #5 clk = ~clk;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_cnt_en, a_cnt_dir, a_cnt_clr, a_cnt_wrap;
    logic [99:0] a_in_data;
    logic [50:0] a_out_sum;
    logic [3:0]  a_cnt_q;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_cnt_en, b_cnt_dir, b_cnt_clr, b_cnt_wrap;
    logic [31:0] b_in_data;
    logic [9:0]  b_out_sum;
    logic [3:0]  b_cnt_q;
    int checks = 0;
    int errors = 0;
    seg_sum_unit dut_a (
        .clk(clk), .async_reset(async_reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sum(a_out_sum),
        .cnt_en(a_cnt_en), .cnt_dir(a_cnt_dir), .cnt_clr(a_cnt_clr),
        .cnt_q(a_cnt_q), .cnt_wrap(a_cnt_wrap)
    );
    seg_sum_unit #(.DATA_W(32), .NSEG(4), .CNT_W(4), .CNT_MOD(8), .CNT_SAT(1)) dut_b (
        .clk(clk), .async_reset(async_reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sum(b_out_sum),
        .cnt_en(b_cnt_en), .cnt_dir(b_cnt_dir), .cnt_clr(b_cnt_clr),
        .cnt_q(b_cnt_q), .cnt_wrap(b_cnt_wrap)
    );
    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask
    logic [31:0] words [5] = '{32'h01020304, 32'hFFFFFFFF, 32'h80808080, 32'h10203040, 32'hFF000001};
    logic [9:0]  sums  [5] = '{10'd10, 10'd1020, 10'd512, 10'd160, 10'd256};
    initial begin
        int tx, rx;
        logic [9:0] held;
        logic held_v;
        {a_in_valid, a_out_ready, a_cnt_en, a_cnt_dir, a_cnt_clr} = '0;
        {b_in_valid, b_out_ready, b_cnt_en, b_cnt_dir, b_cnt_clr} = '0;
        a_in_data = '0;
        b_in_data = '0;
        a_out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_out_valid", 128'(a_out_valid), 128'(0));
        check("rst_out_sum", 128'(a_out_sum), 128'(0));
        check("rst_cnt_q", 128'(a_cnt_q), 128'(0));
        check("rst_cnt_wrap", 128'(a_cnt_wrap), 128'(0));
        check("rst_in_ready", 128'(a_in_ready), 128'(0));
        check("rst_b_in_ready", 128'(b_in_ready), 128'(0));
        async_reset = 1'b0;
        // small and all-ones words through the default unit
        a_in_valid = 1'b1;
        a_in_data = {50'h1, 50'h2};
        #1 check("idle_in_ready", 128'(a_in_ready), 128'(1));
        tick();
        check("lat_edge1_valid", 128'(a_out_valid), 128'(0));
        a_in_data = {50'h3FFFF_FFFFFFFF, 50'h3FFFF_FFFFFFFF};
        tick();
        check("lat_edge2_valid", 128'(a_out_valid), 128'(1));
        check("sum_small", 128'(a_out_sum), 128'(51'h3));
        a_in_valid = 1'b0;
        tick();
        check("sum_ones_valid", 128'(a_out_valid), 128'(1));
        check("sum_ones", 128'(a_out_sum), 128'(51'h7FFFF_FFFFFFFE));
        check("sum_ones_carry", 128'(a_out_sum[50]), 128'(1));
        tick();
        check("drain_valid", 128'(a_out_valid), 128'(0));
        // stream with a 3-cycle stall through the 4-segment unit
        tx = 0;
        rx = 0;
        held_v = 1'b0;
        held = '0;
        for (int c = 0; c < 12; c++) begin
            b_out_ready = !(c >= 3 && c <= 5);
            b_in_valid = tx < 5;
            b_in_data = tx < 5 ? words[tx] : '0;
            #1;
            if (c == 3) check("stall_in_ready_low", 128'(b_in_ready), 128'(0));
            if (c == 6) check("unstall_in_ready_high", 128'(b_in_ready), 128'(1));
            if (held_v) begin
                check("stall_valid_hold", 128'(b_out_valid), 128'(1));
                check("stall_sum_hold", 128'(b_out_sum), 128'(held));
            end
            held_v = b_out_valid && !b_out_ready;
            held = b_out_sum;
            if (b_out_valid && b_out_ready) begin
                if (rx < 5) check($sformatf("stream_sum%0d", rx), 128'(b_out_sum), 128'(sums[rx]));
                rx++;
            end
            if (b_in_valid && b_in_ready) tx++;
            tick();
        end
        b_in_valid = 1'b0;
        check("stream_sent", 128'(tx), 128'(5));
        check("stream_received", 128'(rx), 128'(5));
        // wrapping counter, up through the boundary then down through zero
        a_cnt_en = 1'b1;
        a_cnt_dir = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("up_q%0d", i), 128'(a_cnt_q), 128'(i % 8));
            check($sformatf("up_wrap%0d", i), 128'(a_cnt_wrap), 128'(i == 8));
        end
        a_cnt_dir = 1'b0;
        tick();
        check("down_q0", 128'(a_cnt_q), 128'(0));
        check("down_wrap0", 128'(a_cnt_wrap), 128'(0));
        tick();
        check("down_q7", 128'(a_cnt_q), 128'(7));
        check("down_wrap7", 128'(a_cnt_wrap), 128'(1));
        a_cnt_en = 1'b0;
        tick();
        check("hold_q", 128'(a_cnt_q), 128'(7));
        check("hold_wrap", 128'(a_cnt_wrap), 128'(0));
        // saturating counter
        b_cnt_en = 1'b1;
        b_cnt_dir = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("sat_down_q", 128'(b_cnt_q), 128'(0));
            check("sat_down_wrap", 128'(b_cnt_wrap), 128'(1));
        end
        b_cnt_dir = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("sat_up_q5", 128'(b_cnt_q), 128'(5));
        check("sat_up_wrap5", 128'(b_cnt_wrap), 128'(0));
        b_cnt_clr = 1'b1;
        tick();
        check("clr_q", 128'(b_cnt_q), 128'(0));
        check("clr_wrap", 128'(b_cnt_wrap), 128'(0));
        b_cnt_clr = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check("sat_top_q", 128'(b_cnt_q), 128'(7));
        check("sat_top_wrap_pre", 128'(b_cnt_wrap), 128'(0));
        tick();
        check("sat_top_stay", 128'(b_cnt_q), 128'(7));
        check("sat_top_wrap", 128'(b_cnt_wrap), 128'(1));
        b_cnt_en = 1'b0;
        // asynchronous reset with both stages full
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_in_data = {50'h9, 50'h9};
        tick();
        tick();
        #1 check("full_in_ready", 128'(a_in_ready), 128'(0));
        check("full_out_valid", 128'(a_out_valid), 128'(1));
        async_reset = 1'b1;
        #1;
        check("arst_out_valid", 128'(a_out_valid), 128'(0));
        check("arst_cnt_q", 128'(a_cnt_q), 128'(0));
        check("arst_in_ready", 128'(a_in_ready), 128'(0));
        check("arst_out_sum", 128'(a_out_sum), 128'(0));
        async_reset = 1'b0;
        a_out_ready = 1'b1;
        a_in_data = {50'h5, 50'h7};
        #1 check("post_rst_in_ready", 128'(a_in_ready), 128'(1));
        @(negedge clk);
        check("post_rst_edge1_valid", 128'(a_out_valid), 128'(0));
        a_in_valid = 1'b0;
        tick();
        check("post_rst_edge2_valid", 128'(a_out_valid), 128'(1));
        check("post_rst_sum", 128'(a_out_sum), 128'(51'hC));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
